// File: rtl/fetch_queue.sv
// Instruction prefetch queue between the ibus and the decode stage register.
// Fetches sequential PCs into a DEPTH-entry FIFO, tolerates arbitrary ibus
// latency and decode stalls, and restarts fetch on redirects.
module fetch_queue #(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     PC_W     = 64,
    parameter int unsigned     INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   ireq_valid,
    output logic [PC_W-1:0]        ireq_addr,
    input  logic                   iresp_data_ok,
    input  logic [INSTR_W-1:0]     iresp_data,
    input  logic                   redirect_valid,
    input  logic [PC_W-1:0]        redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [INSTR_W-1:0]     out_instr,
    output logic                   out_exc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned     AW      = $clog2(DEPTH);
    localparam int unsigned     CW      = AW + 1;
    localparam logic [CW-1:0]   FULL    = CW'(DEPTH);
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  ireq_addr_q, ireq_addr_d;
    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic             halted_q, halted_d;
    logic             discard_q, discard_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic               exc_mem   [DEPTH];

    logic               resp;
    logic               accept;
    logic               exc_push;
    logic               push;
    logic               pop;
    logic               busy;
    logic               issue;
    logic [PC_W-1:0]    push_pc;
    logic [INSTR_W-1:0] push_instr;

    // Next-state: redirect overrides push/pop; issue is decided on post-update
    // count/PC so a slot is always reserved for the request being launched.
    always_comb begin
        resp       = (state_q == S_REQ) && iresp_data_ok;
        accept     = resp && !discard_q && !redirect_valid;
        exc_push   = (state_q == S_IDLE) && !halted_q && (fetch_pc_q[1:0] != 2'b00)
                     && (count_q < FULL) && !redirect_valid;
        push       = accept || exc_push;
        pop        = out_valid && out_ready && !redirect_valid;
        push_pc    = accept ? ireq_addr_q : fetch_pc_q;
        push_instr = accept ? iresp_data : '0;
        busy       = (state_q == S_REQ) && !iresp_data_ok;

        fetch_pc_d = fetch_pc_q;
        halted_d   = halted_q;
        discard_d  = discard_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            halted_d   = 1'b0;
            discard_d  = busy;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (exc_push) begin
                halted_d = 1'b1;
            end
            if (resp && discard_q) begin
                discard_d = 1'b0;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        issue       = !busy && !halted_d && (fetch_pc_d[1:0] == 2'b00) && (count_d < FULL);
        state_d     = (busy || issue) ? S_REQ : S_IDLE;
        ireq_addr_d = issue ? fetch_pc_d : ireq_addr_q;
    end

    // Control and pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ireq_addr_q <= '0;
            fetch_pc_q  <= RESET_PC;
            halted_q    <= 1'b0;
            discard_q   <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            ireq_addr_q <= ireq_addr_d;
            fetch_pc_q  <= fetch_pc_d;
            halted_q    <= halted_d;
            discard_q   <= discard_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            pc_mem[wr_ptr_q]    <= push_pc;
            instr_mem[wr_ptr_q] <= push_instr;
            exc_mem[wr_ptr_q]   <= exc_push;
        end
    end

    // Occupancy invariants: never above DEPTH, never a push into a full queue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_count_bound: assert (count_q <= FULL);
            a_no_push_full: assert (!(push && (count_q == FULL)));
        end
    end

    assign ireq_valid = (state_q == S_REQ);
    assign ireq_addr  = ireq_addr_q;
    assign out_valid  = (count_q != '0);
    assign out_pc     = pc_mem[rd_ptr_q];
    assign out_instr  = instr_mem[rd_ptr_q];
    assign out_exc    = exc_mem[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a scripted ibus plus a scoreboard of the
// entries decode is expected to receive, checked by a separate monitor.
module tb_fetch_queue;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned PC_W    = 64;
    localparam int unsigned INSTR_W = 32;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               ireq_valid;
    logic [PC_W-1:0]    ireq_addr;
    logic               iresp_data_ok = 1'b0;
    logic [INSTR_W-1:0] iresp_data = '0;
    logic               redirect_valid = 1'b0;
    logic [PC_W-1:0]    redirect_pc = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic               out_exc;
    logic [2:0]         count;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc;
    } ent_t;

    ent_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   lat      = 1;
    bit   ibus_auto = 1'b1;
    int   wcnt     = 0;

    fetch_queue #(
        .DEPTH(DEPTH),
        .PC_W(PC_W),
        .INSTR_W(INSTR_W),
        .RESET_PC(64'h0000_0000_8000_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ireq_valid(ireq_valid),
        .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok),
        .iresp_data(iresp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_instr(out_instr),
        .out_exc(out_exc),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [63:0] pc, input logic exc);
        ent_t e;
        e.pc    = pc;
        e.instr = exc ? 32'h0 : instr_of(pc);
        e.exc   = exc;
        exp_q.push_back(e);
    endtask

    // One clock; inputs change 1 time unit after the edge. The ibus model
    // answers a request once it has been visible for 'lat' cycles.
    task automatic step();
        @(posedge clk);
        #1;
        if (reset) begin
            iresp_data_ok = 1'b0;
            wcnt = 0;
        end else if (ibus_auto) begin
            if (iresp_data_ok) begin
                iresp_data_ok = 1'b0;
                wcnt = 0;
            end
            if (ireq_valid) begin
                if (wcnt >= lat) begin
                    iresp_data_ok = 1'b1;
                    iresp_data    = instr_of(ireq_addr);
                end else begin
                    wcnt++;
                end
            end
        end
    endtask

    task automatic wait_exp_empty(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        out_ready = 1'b0;
    endtask

    task automatic wait_ireq(input string name, input int budget);
        int n = 0;
        while (!ireq_valid && n < budget) begin
            step();
            n++;
        end
        check(name, 64'(ireq_valid), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic redirect(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    // Monitor: every accepted head entry must match the scoreboard front.
    always @(negedge clk) begin
        ent_t e;
        if (!reset && out_valid && out_ready && !redirect_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL pop_unexpected: got pc=%h instr=%h exc=%b, required no entry",
                         out_pc, out_instr, out_exc);
            end else begin
                e = exp_q.pop_front();
                if ({out_pc, out_instr, out_exc} !== e) begin
                    n_fails++;
                    $display("FAIL pop_entry: got pc=%h instr=%h exc=%b, required pc=%h instr=%h exc=%b",
                             out_pc, out_instr, out_exc, e.pc, e.instr, e.exc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state
        do_reset();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ireq_valid", 64'(ireq_valid), 64'd0);

        // 1: sequential fetch with free-running decode
        lat = 1;
        push_exp(64'h8000_0000, 1'b0);
        push_exp(64'h8000_0004, 1'b0);
        push_exp(64'h8000_0008, 1'b0);
        out_ready = 1'b1;
        wait_exp_empty("t1_drain", 40);

        // 2: decode stall fills the queue, then drains in order
        repeat (20) step();
        check("t2_count_full", 64'(count), 64'd4);
        check("t2_ireq_idle", 64'(ireq_valid), 64'd0);
        check("t2_out_valid", 64'(out_valid), 64'd1);
        check("t2_head_pc", out_pc, 64'h8000_000C);
        push_exp(64'h8000_000C, 1'b0);
        push_exp(64'h8000_0010, 1'b0);
        push_exp(64'h8000_0014, 1'b0);
        push_exp(64'h8000_0018, 1'b0);
        out_ready = 1'b1;
        wait_exp_empty("t2_drain", 40);

        // 3: redirect while a request is outstanding; late response dropped
        do_reset();
        lat = 1;
        push_exp(64'h8000_0000, 1'b0);
        push_exp(64'h8000_0004, 1'b0);
        out_ready = 1'b1;
        n = 0;
        while (!(ireq_valid && ireq_addr == 64'h8000_0008) && n < 30) begin
            step();
            n++;
        end
        check("t3_req8_seen", 64'(ireq_valid && ireq_addr == 64'h8000_0008), 64'd1);
        ibus_auto = 1'b0;
        iresp_data_ok = 1'b0;
        step();
        redirect(64'h8000_1000);
        check("t3_flush_count", 64'(count), 64'd0);
        check("t3_req_held", 64'(ireq_valid), 64'd1);
        check("t3_req_addr_held", ireq_addr, 64'h8000_0008);
        step();
        step();
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hDEAD_BEEF;
        step();
        iresp_data_ok = 1'b0;
        wcnt = 0;
        ibus_auto = 1'b1;
        check("t3_dropped_count", 64'(count), 64'd0);
        check("t3_new_req", 64'(ireq_valid), 64'd1);
        check("t3_new_addr", ireq_addr, 64'h8000_1000);
        push_exp(64'h8000_1000, 1'b0);
        wait_exp_empty("t3_drain", 20);

        // 4: misaligned redirect yields one exception entry and halts fetch
        redirect(64'h8000_0102);
        check("t4_flush_count", 64'(count), 64'd0);
        push_exp(64'h8000_0102, 1'b1);
        out_ready = 1'b1;
        wait_exp_empty("t4_exc_entry", 20);
        repeat (5) step();
        check("t4_halted_ireq", 64'(ireq_valid), 64'd0);
        check("t4_halted_count", 64'(count), 64'd0);
        redirect(64'h8000_0200);
        check("t4_resume_req", 64'(ireq_valid), 64'd1);
        check("t4_resume_addr", ireq_addr, 64'h8000_0200);
        push_exp(64'h8000_0200, 1'b0);
        push_exp(64'h8000_0204, 1'b0);
        out_ready = 1'b1;
        wait_exp_empty("t4_drain", 30);

        // 5: redirect coinciding with data_ok and a pop
        do_reset();
        lat = 0;
        n = 0;
        while (count != 3'd2 && n < 10) begin
            step();
            n++;
        end
        check("t5_count_two", 64'(count), 64'd2);
        out_ready = 1'b1;
        redirect(64'h8000_2000);
        check("t5_empty", 64'(out_valid), 64'd0);
        check("t5_count", 64'(count), 64'd0);
        check("t5_req", 64'(ireq_valid), 64'd1);
        check("t5_req_addr", ireq_addr, 64'h8000_2000);
        push_exp(64'h8000_2000, 1'b0);
        push_exp(64'h8000_2004, 1'b0);
        push_exp(64'h8000_2008, 1'b0);
        wait_exp_empty("t5_drain", 30);

        // 6: reset mid-request with two entries queued
        do_reset();
        lat = 3;
        n = 0;
        while (!(count == 3'd2 && ireq_valid) && n < 40) begin
            step();
            n++;
        end
        check("t6_setup", 64'(count == 3'd2 && ireq_valid), 64'd1);
        reset = 1'b1;
        step();
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_count", 64'(count), 64'd0);
        check("t6_ireq", 64'(ireq_valid), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        push_exp(64'h8000_0000, 1'b0);
        out_ready = 1'b1;
        wait_ireq("t6_req_seen", 10);
        check("t6_first_addr", ireq_addr, 64'h8000_0000);
        wait_exp_empty("t6_drain", 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
